// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the register-file write path.
//   XLEN        : datapath width
//   REG_ADDR_W  : register address width (x0..x31)
//   NUM_REGS    : number of architectural registers
//   wb_entry_t  : buffered writeback {rd, data}
//   reg_onehot  : one-hot decode of a register index, with x0 mapping to zero
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired to zero, so it never tracks hazards or pending state.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    reg_onehot = '0;
    if (r != '0) begin
      reg_onehot[r] = 1'b1;
    end
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter_if
// Load-response handshake between the memory stage and the write arbiter.
//   ld_rsp_valid : response present this cycle            (master -> slave)
//   ld_rsp_ready : response accepted when valid && ready  (slave  -> master)
//   ld_rsp_rd    : destination register of the response   (master -> slave)
//   ld_rsp_data  : loaded data                            (master -> slave)
// Modports: master = memory stage, slave = write arbiter.
// ----------------------------------------------------------------------------
interface regfile_write_arbiter_if
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN
);

  logic                  ld_rsp_valid;
  logic                  ld_rsp_ready;
  logic [REG_ADDR_W-1:0] ld_rsp_rd;
  logic [DATA_W-1:0]     ld_rsp_data;

  modport master (
    output ld_rsp_valid,
    output ld_rsp_rd,
    output ld_rsp_data,
    input  ld_rsp_ready
  );

  modport slave (
    input  ld_rsp_valid,
    input  ld_rsp_rd,
    input  ld_rsp_data,
    output ld_rsp_ready
  );

endinterface

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Small skid FIFO holding accepted load responses until the write port is free.
//   clk, reset : rising-edge clock, asynchronous active-low reset
//   push       : enqueue push_entry (ignored when full)
//   push_entry : {rd, data} to enqueue
//   pop        : dequeue the head (ignored when empty)
//   head       : current head entry, valid only when !empty
//   full/empty : occupancy flags from the registered count
//   count      : number of queued entries, width clog2(DEPTH)+1
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ----------------------------------------------------------------------------
module wb_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic push_ok;
  logic pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage carries no reset: contents are only observed through the
  // pointers, which are reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/regfile_write_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_write_arbiter
// Merges single-cycle ALU/jump writebacks and buffered load responses onto the
// register file's single write port, tracks registers awaiting a load, and
// stalls decode on any RAW/WAW hazard against an outstanding load.
//   clk, reset        : rising-edge clock, asynchronous active-low reset
//   alu_we/rd/wd      : ALU writeback request (highest priority on the port)
//   ld_issue/_rd      : a load to ld_issue_rd left decode this cycle
//   ld_rsp            : load-response handshake (slave side)
//   dec_rs1/rs2/rd    : register fields of the instruction in decode
//   stall             : decode must hold
//   we3/a3/wd3        : register file write port (combinational)
//   pending           : bitmap of registers awaiting a load writeback
//   err_unexpected    : sticky, a response arrived for a non-pending register
// ----------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             alu_we,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]                  alu_wd,
  input  logic                             ld_issue,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] ld_issue_rd,
  regfile_write_arbiter_if.slave           ld_rsp,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs1,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rs2,
  input  logic [riscv_pkg::REG_ADDR_W-1:0] dec_rd,
  output logic                             stall,
  output logic                             we3,
  output logic [riscv_pkg::REG_ADDR_W-1:0] a3,
  output logic [XLEN-1:0]                  wd3,
  output logic [riscv_pkg::NUM_REGS-1:0]   pending,
  output logic                             err_unexpected
);

  import riscv_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_entry_t          push_entry;
  wb_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_push;
  logic               fifo_pop;

  logic               alu_hit;
  logic               rsp_accept;

  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] hazard_vec;
  logic                err_reg;
  logic                err_next;

  // --------------------------------------------------------------------------
  // Load-response intake
  // --------------------------------------------------------------------------
  // Ready looks only at the registered count, so a pop in the same cycle does
  // not open a slot early; this keeps ready free of any path from alu_we.
  assign ld_rsp.ld_rsp_ready = reset && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign rsp_accept          = ld_rsp.ld_rsp_valid && ld_rsp.ld_rsp_ready;
  assign fifo_push           = rsp_accept && !fifo_full;

  assign push_entry.rd   = ld_rsp.ld_rsp_rd;
  assign push_entry.data = ld_rsp.ld_rsp_data;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_wb_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // --------------------------------------------------------------------------
  // Write-port arbitration
  // --------------------------------------------------------------------------
  // An ALU write to x0 is a no-op and leaves the port to the FIFO.
  assign alu_hit  = alu_we && (alu_rd != '0);
  // A head with rd=0 still pops; it just never raises we3.
  assign fifo_pop = reset && !fifo_empty && !alu_hit;

  always_comb begin
    we3 = 1'b0;
    a3  = '0;
    wd3 = '0;
    if (reset) begin
      if (alu_hit) begin
        we3 = 1'b1;
        a3  = alu_rd;
        wd3 = alu_wd;
      end else if (!fifo_empty) begin
        we3 = (head.rd != '0);
        a3  = head.rd;
        wd3 = head.data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pending bitmap
  // --------------------------------------------------------------------------
  assign set_vec = ld_issue ? reg_onehot(ld_issue_rd) : '0;
  assign clr_vec = fifo_pop ? reg_onehot(head.rd)     : '0;

  // A new load to a register whose previous load commits this same edge must
  // remain pending, so set dominates clear.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
      if (gi == 0) begin : g_x0
        assign pending_next[gi] = 1'b0;
      end else begin : g_xn
        assign pending_next[gi] = set_vec[gi] | (pending_reg[gi] & ~clr_vec[gi]);
      end
    end
  endgenerate

  // A response is expected only if its register is already pending or a load
  // to it is being issued at this very edge.
  assign err_next = err_reg
                  | (rsp_accept
                     && (ld_rsp.ld_rsp_rd != '0)
                     && !pending_reg[ld_rsp.ld_rsp_rd]
                     && !set_vec[ld_rsp.ld_rsp_rd]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      err_reg     <= err_next;
    end
  end

  // --------------------------------------------------------------------------
  // Decode stall: registered state only, no path from ld_issue.
  // --------------------------------------------------------------------------
  assign hazard_vec = reg_onehot(dec_rs1) | reg_onehot(dec_rs2) | reg_onehot(dec_rd);
  assign stall      = reset && |(pending_reg & hazard_vec);

  assign pending        = pending_reg;
  assign err_unexpected = err_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_we = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_wd = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic [4:0]  dec_rs1 = '0;
  logic [4:0]  dec_rs2 = '0;
  logic [4:0]  dec_rd = '0;
  logic        stall;
  logic        we3;
  logic [4:0]  a3;
  logic [31:0] wd3;
  logic [31:0] pending;
  logic        err_unexpected;

  always #5 clk = ~clk;

  regfile_write_arbiter_if ld_rsp ();

  regfile_write_arbiter #(
    .XLEN       (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_we         (alu_we),
    .alu_rd         (alu_rd),
    .alu_wd         (alu_wd),
    .ld_issue       (ld_issue),
    .ld_issue_rd    (ld_issue_rd),
    .ld_rsp         (ld_rsp),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rd         (dec_rd),
    .stall          (stall),
    .we3            (we3),
    .a3             (a3),
    .wd3            (wd3),
    .pending        (pending),
    .err_unexpected (err_unexpected)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard: accepted responses are queued as expected load writebacks and
  // popped when the write port serves them. Pending/err/stall are tracked
  // alongside.
  // --------------------------------------------------------------------------
  logic [36:0] exp_q[$];
  logic [31:0] m_pend = '0;
  logic        m_err  = 1'b0;

  initial begin : monitor
    logic        will_pop;
    logic        acc;
    logic        s_issue;
    logic [4:0]  s_issue_rd;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic [36:0] e;
    logic        q_full;
    logic        exp_stall;
    will_pop = 1'b0;
    acc      = 1'b0;
    forever begin
      @(negedge clk);
      will_pop = 1'b0;
      acc      = 1'b0;
      if (!reset) begin
        chk("rst_we3",   we3, 0);
        chk("rst_a3",    a3, 0);
        chk("rst_wd3",   wd3, 0);
        chk("rst_ready", ld_rsp.ld_rsp_ready, 0);
        chk("rst_stall", stall, 0);
        chk("rst_pend",  pending, 0);
        chk("rst_err",   err_unexpected, 0);
        exp_q.delete();
        m_pend = '0;
        m_err  = 1'b0;
      end else begin
        q_full = (exp_q.size() >= 2);
        chk("ready", ld_rsp.ld_rsp_ready, !q_full);
        if (alu_we && alu_rd != 0) begin
          chk("alu_we3", we3, 1);
          chk("alu_a3",  a3, alu_rd);
          chk("alu_wd3", wd3, alu_wd);
        end else if (exp_q.size() > 0) begin
          e = exp_q[0];
          will_pop = 1'b1;
          chk("ld_we3", we3, (e[36:32] != 0));
          if (e[36:32] != 0) begin
            chk("ld_a3",  a3, e[36:32]);
            chk("ld_wd3", wd3, e[31:0]);
          end
        end else begin
          chk("idle_we3", we3, 0);
        end
        chk("pending", pending, m_pend);
        chk("err", err_unexpected, m_err);
        exp_stall = (dec_rs1 != 0 && m_pend[dec_rs1]) ||
                    (dec_rs2 != 0 && m_pend[dec_rs2]) ||
                    (dec_rd  != 0 && m_pend[dec_rd]);
        chk("stall", stall, exp_stall);
        acc        = ld_rsp.ld_rsp_valid && !q_full;
        s_rd       = ld_rsp.ld_rsp_rd;
        s_data     = ld_rsp.ld_rsp_data;
        s_issue    = ld_issue;
        s_issue_rd = ld_issue_rd;
      end
      @(posedge clk);
      if (reset) begin
        if (acc && s_rd != 0 && !m_pend[s_rd] && !(s_issue && s_issue_rd == s_rd))
          m_err = 1'b1;
        if (will_pop) begin
          e = exp_q.pop_front();
          if (e[36:32] != 0) m_pend[e[36:32]] = 1'b0;
        end
        if (s_issue && s_issue_rd != 0) m_pend[s_issue_rd] = 1'b1;
        if (acc) exp_q.push_back({s_rd, s_data});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called just after a rising edge)
  // --------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [4:0] rd);
    ld_issue    = 1'b1;
    ld_issue_rd = rd;
    tick(1);
    ld_issue    = 1'b0;
  endtask

  // Holds valid until accepted; returns just after the accepting edge.
  task automatic send_rsp(input logic [4:0] rd, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    ld_rsp.ld_rsp_valid = 1'b1;
    ld_rsp.ld_rsp_rd    = rd;
    ld_rsp.ld_rsp_data  = d;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = ld_rsp.ld_rsp_ready;
      @(posedge clk);
      #1;
    end
    ld_rsp.ld_rsp_valid = 1'b0;
    chk("rsp_accepted", acc, 1);
  endtask

  initial begin : stimulus
    ld_rsp.ld_rsp_valid = 1'b0;
    ld_rsp.ld_rsp_rd    = '0;
    ld_rsp.ld_rsp_data  = '0;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("init_ready", ld_rsp.ld_rsp_ready, 1);
    chk("init_pend",  pending, 0);
    @(posedge clk); #1;

    // Single load to x5, response three cycles after issue.
    issue(5'd5);
    dec_rs1 = 5'd5;
    @(negedge clk);
    chk("t1_stall_wait", stall, 1);
    @(posedge clk); #1;
    tick(1);
    send_rsp(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_we3",   we3, 1);
    chk("t1_a3",    a3, 5);
    chk("t1_wd3",   wd3, 32'hDEAD_BEEF);
    chk("t1_stall", stall, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_pend5",       pending[5], 0);
    chk("t1_stall_clear", stall, 0);
    @(posedge clk); #1;
    dec_rs1 = '0;

    // ALU hogs the port for 4 cycles while three responses arrive.
    issue(5'd3);
    issue(5'd4);
    issue(5'd9);
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          alu_we = 1'b1;
          alu_rd = 5'd7;
          alu_wd = 32'h7000_0000 + 32'(i);
          tick(1);
        end
        alu_we = 1'b0;
      end
      begin
        send_rsp(5'd3, 32'h3333_0003);
        send_rsp(5'd4, 32'h4444_0004);
        @(negedge clk);
        chk("t3_ready_full", ld_rsp.ld_rsp_ready, 0);
        @(posedge clk); #1;
        send_rsp(5'd9, 32'h9999_0009);
      end
    join
    tick(4);
    @(negedge clk);
    chk("t3_pend_drained", pending & 32'h0000_0218, 0);
    @(posedge clk); #1;

    // Same-edge set and clear of x6: set wins.
    issue(5'd6);
    send_rsp(5'd6, 32'h0606_0606);
    ld_issue    = 1'b1;
    ld_issue_rd = 5'd6;
    dec_rs2     = 5'd6;
    tick(1);
    ld_issue    = 1'b0;
    @(negedge clk);
    chk("t4_pend6", pending[6], 1);
    chk("t4_stall", stall, 1);
    @(posedge clk); #1;
    send_rsp(5'd6, 32'h0606_1111);
    tick(1);
    @(negedge clk);
    chk("t4_pend6_clear", pending[6], 0);
    @(posedge clk); #1;
    dec_rs2 = '0;

    // Unexpected response to x12, then a response to x0.
    send_rsp(5'd12, 32'h1234_5678);
    @(negedge clk);
    chk("t5_we3", we3, 1);
    chk("t5_a3",  a3, 12);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_err", err_unexpected, 1);
    @(posedge clk); #1;
    send_rsp(5'd0, 32'hAAAA_5555);
    @(negedge clk);
    chk("t5_x0_we3", we3, 0);
    @(posedge clk); #1;
    tick(1);
    @(negedge clk);
    chk("t5_err_sticky", err_unexpected, 1);
    chk("t5_ready",      ld_rsp.ld_rsp_ready, 1);
    @(posedge clk); #1;

    // ALU write to x0 does not block the FIFO head.
    issue(5'd8);
    send_rsp(5'd8, 32'h8888_8888);
    alu_we = 1'b1;
    alu_rd = 5'd0;
    alu_wd = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t6_we3", we3, 1);
    chk("t6_a3",  a3, 8);
    chk("t6_wd3", wd3, 32'h8888_8888);
    @(posedge clk); #1;
    alu_we = 1'b0;
    tick(1);

    // Reset with two responses queued behind a busy ALU.
    alu_we = 1'b1;
    alu_rd = 5'd7;
    alu_wd = 32'h0000_7777;
    issue(5'd10);
    issue(5'd11);
    send_rsp(5'd10, 32'h1010_1010);
    send_rsp(5'd11, 32'h1111_1111);
    @(negedge clk);
    chk("t2_ready_full", ld_rsp.ld_rsp_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t2_we3",   we3, 0);
    chk("t2_pend",  pending, 0);
    chk("t2_ready", ld_rsp.ld_rsp_ready, 0);
    @(posedge clk); #1;
    alu_we = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    chk("t2_ready_rel", ld_rsp.ld_rsp_ready, 1);
    chk("t2_we3_rel",   we3, 0);
    chk("t2_err_rel",   err_unexpected, 0);
    @(posedge clk); #1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
